mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-port, variable-latency backing memory between the fetch stage (read-only) and the memory stage (read/write). It sits between the pipeline's fetch/memory stages and the memory macro. It registers the winning request, drives the backend handshake until completion, and returns read data with a one-cycle done pulse. It also drives per-port stall signals so the hazard logic can freeze the pipeline while a port waits.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Byte-offset bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - backend memory handshake bus between arbiter and memory macro
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of data grants made while fetch waits
module arb_starve_ctr #(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  output logic                d_stall,
  mem_port_arbiter_if.master  mem
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(ALIGN_MASK));

  arb_state_e state;
  logic       at_max;
  logic       d_live;
  logic       d_bad;
  logic       d_ok;
  logic       grant_i;
  logic       grant_d;
  logic       win_port;

  // d_err is still high in the cycle after the error while the stale request is
  // being withdrawn, so that request must not be seen again.
  assign d_live   = d_req && !d_err;
  assign d_bad    = d_live && is_misaligned(d_addr[1:0]);
  assign d_ok     = d_live && !is_misaligned(d_addr[1:0]);
  assign grant_i  = (state == IDLE) && !d_bad && if_req && (!d_ok || at_max);
  assign grant_d  = (state == IDLE) && !d_bad && d_ok && !grant_i;
  assign win_port = grant_i ? PORT_I : PORT_D;

  assign if_stall = if_req && !if_done;
  assign d_stall  = d_req && !(d_done || d_err);

  arb_starve_ctr #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_d && if_req),
    .clr   (grant_i || (grant_d && !if_req)),
    .at_max(at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      if_done       <= 1'b0;
      d_done        <= 1'b0;
      d_err         <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (d_bad) begin
            d_err <= 1'b1;
          end else if (grant_i || grant_d) begin
            state       <= (win_port == PORT_D) ? BUSY_D : BUSY_I;
            mem.mem_req <= 1'b1;
            if (win_port == PORT_D) begin
              mem.mem_we    <= d_we;
              mem.mem_addr  <= d_addr & WORD_MASK;
              mem.mem_wdata <= d_wdata;
            end else begin
              mem.mem_we    <= 1'b0;
              mem.mem_addr  <= if_addr & WORD_MASK;
              mem.mem_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= DONE;
            if (state == BUSY_I) begin
              if_rdata <= mem.mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem.mem_we) begin
                d_rdata <= mem.mem_rdata;
              end
              d_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        d_stall;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_CONSEC(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_done (if_done),
    .if_stall(if_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .d_stall (d_stall),
    .mem     (mem)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic [31:0] exp_addr;
    int          exp_done;
    logic        perturb;
  } vec_t;

  vec_t vecs[5];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    if_req        = 1'b0;
    if_addr       = '0;
    d_req         = 1'b0;
    d_we          = 1'b0;
    d_addr        = '0;
    d_wdata       = '0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i, input string tag);
    vec_t        v;
    int          first_req;
    int          done_cyc;
    logic        addr_ok, we_ok, wd_ok, stall_ok, other_ok, stall, mydone;
    logic [31:0] got_rdata;
    v = vecs[i];
    first_req = -1; done_cyc = -1; got_rdata = '0;
    addr_ok = 1'b1; we_ok = 1'b1; wd_ok = 1'b1; stall_ok = 1'b1; other_ok = 1'b1;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c < 40; c++) begin
      if (v.perturb && c == 2) begin
        d_addr  = 32'h0000_0FFC;
        d_wdata = 32'h0;
      end
      @(negedge clk);
      if (mem.mem_req) begin
        if (first_req < 0) first_req = c;
        if (mem.mem_addr !== v.exp_addr) addr_ok = 1'b0;
        if (mem.mem_we !== (v.is_d & v.we)) we_ok = 1'b0;
        if (v.is_d && v.we && mem.mem_wdata !== v.wdata) wd_ok = 1'b0;
      end
      stall = v.is_d ? d_stall : if_stall;
      if (stall !== (c < v.exp_done)) stall_ok = 1'b0;
      if (v.is_d ? (if_done || d_err) : (d_done || d_err)) other_ok = 1'b0;
      mydone = v.is_d ? d_done : if_done;
      if (mydone && done_cyc < 0) begin
        done_cyc  = c;
        got_rdata = v.is_d ? d_rdata : if_rdata;
      end
      mem.mem_ready = mem.mem_req && (first_req >= 0) && (c == first_req + v.k);
      mem.mem_rdata = mem.mem_ready ? v.rdata : 32'h0;
      if (done_cyc >= 0) break;
    end
    @(posedge clk); #1;
    idle_inputs();
    check({tag, " mem_req_cycle"}, first_req, 1);
    check({tag, " done_cycle"}, done_cyc, v.exp_done);
    check({tag, " mem_addr"}, addr_ok, 1'b1);
    check({tag, " mem_we"}, we_ok, 1'b1);
    check({tag, " stall"}, stall_ok, 1'b1);
    check({tag, " other_port_quiet"}, other_ok, 1'b1);
    if (v.is_d && v.we) check({tag, " mem_wdata"}, wd_ok, 1'b1);
    else check({tag, " rdata"}, got_rdata, v.rdata);
  endtask

  initial begin
    int          err_cyc, err_cnt, n_grant;
    logic        req_seen, done_seen;
    logic [9:0]  order;

    vecs[0] = '{is_d:1'b1, we:1'b1, addr:32'h100, wdata:32'hDEADBEEF, rdata:32'h0,
                k:1, exp_addr:32'h100, exp_done:3, perturb:1'b0};
    vecs[1] = '{is_d:1'b0, we:1'b0, addr:32'h40, wdata:32'h0, rdata:32'h20080005,
                k:0, exp_addr:32'h40, exp_done:2, perturb:1'b0};
    vecs[2] = '{is_d:1'b1, we:1'b0, addr:32'h2000, wdata:32'h11111111, rdata:32'hCAFEF00D,
                k:2, exp_addr:32'h2000, exp_done:4, perturb:1'b0};
    vecs[3] = '{is_d:1'b1, we:1'b1, addr:32'h300, wdata:32'h12345678, rdata:32'h0,
                k:10, exp_addr:32'h300, exp_done:12, perturb:1'b1};
    vecs[4] = '{is_d:1'b0, we:1'b0, addr:32'h46, wdata:32'h0, rdata:32'hA5A50F0F,
                k:3, exp_addr:32'h44, exp_done:5, perturb:1'b0};

    // Reset values, with both requests high so stalls show during reset
    idle_inputs();
    rst_n  = 1'b0;
    if_req = 1'b1;
    d_req  = 1'b1;
    d_addr = 32'h100;
    repeat (3) @(negedge clk);
    check("rst if_stall", if_stall, 1'b1);
    check("rst d_stall", d_stall, 1'b1);
    check("rst mem_req", mem.mem_req, 1'b0);
    check("rst mem_we", mem.mem_we, 1'b0);
    check("rst mem_addr", mem.mem_addr, 32'h0);
    check("rst mem_wdata", mem.mem_wdata, 32'h0);
    check("rst if_rdata", if_rdata, 32'h0);
    check("rst d_rdata", d_rdata, 32'h0);
    check("rst pulses", {if_done, d_done, d_err}, 3'b000);
    do_reset();

    for (int i = 0; i < 5; i++) run_vec(i, $sformatf("vec%0d", i));

    // Misaligned data access: one d_err pulse, no backend traffic
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h103;
    err_cyc = -1; err_cnt = 0; req_seen = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem.mem_req) req_seen = 1'b1;
      if (d_done) done_seen = 1'b1;
      if (d_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (c == 0) check("misalign stall_c0", d_stall, 1'b1);
      @(posedge clk); #1;
      if (err_cyc >= 0) d_req = 1'b0;
    end
    check("misalign err_cycle", err_cyc, 1);
    check("misalign err_count", err_cnt, 1);
    check("misalign mem_req", req_seen, 1'b0);
    check("misalign d_done", done_seen, 1'b0);
    idle_inputs();

    // Contention with both requests held: D,D,D,D,I,D,D,D,D,I
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    n_grant = 0; order = '0;
    for (int c = 0; c < 200 && n_grant < 10; c++) begin
      @(negedge clk);
      if (if_done && n_grant < 10) begin order[n_grant] = 1'b1; n_grant++; end
      if (d_done && n_grant < 10) begin order[n_grant] = 1'b0; n_grant++; end
      mem.mem_ready = mem.mem_req && !mem.mem_ready;
      mem.mem_rdata = 32'h0;
    end
    check("contention grants", n_grant, 10);
    check("contention order", order, 10'b10_0001_0000);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset asserted while a data write waits on the backend
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55AA55AA;
    repeat (3) @(negedge clk);
    check("midrst busy mem_req", mem.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    d_req = 1'b0;
    #1 check("midrst async drop", mem.mem_req, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    req_seen = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem.mem_req) req_seen = 1'b1;
      if (d_done || if_done) done_seen = 1'b1;
    end
    check("midrst no mem_req", req_seen, 1'b0);
    check("midrst no done", done_seen, 1'b0);
    run_vec(1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
